// File: rtl/core_fd_pkg.sv
// core_fd_pkg: shared types and helpers for the fetch-to-decode receiver.
//   fd_pkt_t       - one buffered fetch packet {istr, pc, jump, is_c}
//   is_compressed  - classifies an instruction from its two low bits
//   pc_succ        - sequential successor PC (wraps mod 2^32)
package core_fd_pkg;

  localparam int ISTR_W = 32;
  localparam int PC_W   = 32;

  typedef struct packed {
    logic [ISTR_W-1:0] istr;
    logic [PC_W-1:0]   pc;
    logic              jump;
    logic              is_c;
  } fd_pkt_t;

  // 16-bit encodings are everything whose low two bits are not 2'b11.
  function automatic logic is_compressed(input logic [1:0] lo);
    return (lo != 2'b11);
  endfunction

  function automatic logic [PC_W-1:0] pc_succ(input logic [PC_W-1:0] pc,
                                               input logic             is_c);
    return pc + (is_c ? PC_W'(2) : PC_W'(4));
  endfunction

endpackage

// File: rtl/core_fd_fifo.sv
// core_fd_fifo: small circular FIFO with registered full/empty flags.
// Ports:
//   clk, srst        - clock, synchronous active-high reset
//   push_i / wdata_i - write request and data (ignored when full)
//   pop_i            - read request (ignored when empty)
//   flush_i          - empties the FIFO; wins over push and pop
//   rdata_o          - head entry, always driven (also when empty)
//   full_o / empty_o - registered status flags
module core_fd_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic srst,
  input  logic push_i,
  input  logic pop_i,
  input  logic flush_i,
  input  T     wdata_i,
  output T     rdata_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  assign do_push = push_i && !full_q && !flush_i;
  assign do_pop  = pop_i && !empty_q && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage is reset so the head payload is well defined (all zero)
  // straight out of reset, before anything has been written.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/core_fd_rx.sv
// core_fd_rx: fetch-to-decode receiver.
// Terminates the fd_* valid/ready stream, buffers packets, classifies each
// instruction as compressed or not, presents the head to decode with its
// successor PC, and flags (stickily) any PC discontinuity not marked as a jump.
// Ports:
//   clk, rest                      - clock, synchronous active-high reset
//   fd_istr/fd_pc/fd_jump/fd_valid - packet from fetch
//   fd_ready                       - receiver can accept (from registered state)
//   flush_en                       - drop all buffered packets
//   ctr_stop                       - hold head, suppress id_valid
//   id_istr/id_pc/id_pc_next/id_is_c/id_jump/id_valid - head to decode
//   id_ready                       - decode accepts head
//   seq_err                        - sticky PC-discontinuity flag
module core_fd_rx
  import core_fd_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rest,
  input  logic [ISTR_W-1:0] fd_istr,
  input  logic [PC_W-1:0]   fd_pc,
  input  logic              fd_jump,
  input  logic              fd_valid,
  output logic              fd_ready,
  input  logic              flush_en,
  input  logic              ctr_stop,
  output logic [ISTR_W-1:0] id_istr,
  output logic [PC_W-1:0]   id_pc,
  output logic [PC_W-1:0]   id_pc_next,
  output logic              id_is_c,
  output logic              id_jump,
  output logic              id_valid,
  input  logic              id_ready,
  output logic              seq_err
);

  fd_pkt_t         pkt_in;
  fd_pkt_t         head;
  logic            in_is_c;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [PC_W-1:0] exp_pc_q, exp_pc_d;
  logic            exp_valid_q, exp_valid_d;
  logic            seq_err_q, seq_err_d;

  assign in_is_c = is_compressed(fd_istr[1:0]);

  always_comb begin
    pkt_in.istr = in_is_c ? {16'h0000, fd_istr[15:0]} : fd_istr;
    pkt_in.pc   = fd_pc;
    pkt_in.jump = fd_jump;
    pkt_in.is_c = in_is_c;
  end

  // fd_ready depends only on the registered full flag (no path from decode
  // stall back to fetch); held low while reset is asserted.
  assign fd_ready = !fifo_full && !rest;
  assign id_valid = !fifo_empty && !ctr_stop;
  assign push     = fd_valid && fd_ready && !flush_en;
  assign pop      = id_valid && id_ready;

  core_fd_fifo #(
    .DEPTH (DEPTH),
    .T     (fd_pkt_t)
  ) u_fifo (
    .clk     (clk),
    .srst    (rest),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush_en),
    .wdata_i (pkt_in),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign id_istr    = head.istr;
  assign id_pc      = head.pc;
  assign id_pc_next = pc_succ(head.pc, head.is_c);
  assign id_is_c    = head.is_c;
  assign id_jump    = head.jump;

  // Sequence tracker: each accepted packet must start where the previous one
  // ended, unless it is the first packet after a redirect.
  always_comb begin
    exp_pc_d    = exp_pc_q;
    exp_valid_d = exp_valid_q;
    seq_err_d   = seq_err_q;
    if (flush_en) begin
      exp_valid_d = 1'b0;
    end else if (push) begin
      if (exp_valid_q && !fd_jump && (fd_pc != exp_pc_q)) seq_err_d = 1'b1;
      exp_pc_d    = pc_succ(fd_pc, in_is_c);
      exp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      exp_pc_q    <= '0;
      exp_valid_q <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      exp_pc_q    <= exp_pc_d;
      exp_valid_q <= exp_valid_d;
      seq_err_q   <= seq_err_d;
    end
  end

  assign seq_err = seq_err_q;

endmodule

// File: tb/tb_core_fd_rx.sv
// tb_core_fd_rx: scoreboard bench for core_fd_rx (DEPTH=2).
module tb_core_fd_rx;

  logic        clk;
  logic        rest;
  logic [31:0] fd_istr;
  logic [31:0] fd_pc;
  logic        fd_jump;
  logic        fd_valid;
  logic        fd_ready;
  logic        flush_en;
  logic        ctr_stop;
  logic [31:0] id_istr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_next;
  logic        id_is_c;
  logic        id_jump;
  logic        id_valid;
  logic        id_ready;
  logic        seq_err;

  typedef struct {
    logic [31:0] istr;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        is_c;
    logic        jump;
  } exp_t;

  exp_t sb_q[$];
  int   vectors_applied = 0;
  int   miscompares     = 0;
  int   pop_count       = 0;

  core_fd_rx #(.DEPTH(2)) dut (
    .clk        (clk),
    .rest       (rest),
    .fd_istr    (fd_istr),
    .fd_pc      (fd_pc),
    .fd_jump    (fd_jump),
    .fd_valid   (fd_valid),
    .fd_ready   (fd_ready),
    .flush_en   (flush_en),
    .ctr_stop   (ctr_stop),
    .id_istr    (id_istr),
    .id_pc      (id_pc),
    .id_pc_next (id_pc_next),
    .id_is_c    (id_is_c),
    .id_jump    (id_jump),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .seq_err    (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors_applied++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold a packet on fd_* until the receiver takes it (bounded wait).
  task automatic send(input logic [31:0] pc, input logic [31:0] istr, input logic jump);
    int n;
    bit ok;
    n  = 0;
    ok = 0;
    fd_pc    = pc;
    fd_istr  = istr;
    fd_jump  = jump;
    fd_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (fd_ready) ok = 1;
      else n++;
    end
    chk("send_accept", {31'b0, ok}, 32'd1);
    step();
    fd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      step();
      n++;
    end
    chk("drain", sb_q.size(), 32'd0);
  endtask

  // Reference model of what decode should see, built from fetch stimulus.
  function automatic exp_t model(input logic [31:0] pc, input logic [31:0] istr, input logic jump);
    exp_t e;
    e.is_c    = (istr[1:0] != 2'b11);
    e.istr    = e.is_c ? (istr & 32'h0000_FFFF) : istr;
    e.pc      = pc;
    e.pc_next = e.is_c ? pc + 32'd2 : pc + 32'd4;
    e.jump    = jump;
    return e;
  endfunction

  // Monitor: pop/compare on decode handshake, push on fetch handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rest) begin
      sb_q.delete();
    end else begin
      if (id_valid && id_ready) begin
        chk("sb_nonempty", {31'b0, (sb_q.size() != 0)}, 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          pop_count++;
          $display("pop  pc=%h istr=%h next=%h c=%0d j=%0d", id_pc, id_istr, id_pc_next, id_is_c, id_jump);
          chk("id_istr", id_istr, e.istr);
          chk("id_pc", id_pc, e.pc);
          chk("id_pc_next", id_pc_next, e.pc_next);
          chk("id_is_c", {31'b0, id_is_c}, {31'b0, e.is_c});
          chk("id_jump", {31'b0, id_jump}, {31'b0, e.jump});
        end
      end
      if (flush_en) begin
        sb_q.delete();
      end else if (fd_valid && fd_ready) begin
        $display("push pc=%h istr=%h jump=%0d", fd_pc, fd_istr, fd_jump);
        sb_q.push_back(model(fd_pc, fd_istr, fd_jump));
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_fd_ready"}, {31'b0, fd_ready}, 32'd0);
    chk({tag, "_id_valid"}, {31'b0, id_valid}, 32'd0);
    chk({tag, "_id_istr"}, id_istr, 32'd0);
    chk({tag, "_id_pc"}, id_pc, 32'd0);
    chk({tag, "_id_pc_next"}, id_pc_next, 32'd4);
    chk({tag, "_id_is_c"}, {31'b0, id_is_c}, 32'd0);
    chk({tag, "_id_jump"}, {31'b0, id_jump}, 32'd0);
    chk({tag, "_seq_err"}, {31'b0, seq_err}, 32'd0);
  endtask

  initial begin
    int pops0;
    rest = 1'b1; fd_istr = '0; fd_pc = '0; fd_jump = 1'b0; fd_valid = 1'b0;
    flush_en = 1'b0; ctr_stop = 1'b0; id_ready = 1'b0;
    step(); step();
    check_reset_state("rst");
    rest = 1'b0;
    #1;
    chk("ready_after_rst", {31'b0, fd_ready}, 32'd1);

    // Basic stream: uncompressed, compressed, uncompressed.
    id_ready = 1'b1;
    send(32'h0, 32'h0000_0013, 1'b0);
    send(32'h4, 32'hDEAD_4501, 1'b0);
    send(32'h6, 32'h0000_0013, 1'b0);
    drain();
    chk("stream_pops", pop_count, 32'd3);
    chk("stream_seq_err", {31'b0, seq_err}, 32'd0);

    // Backpressure: two fill the FIFO, third waits for a pop.
    id_ready = 1'b0;
    pops0 = pop_count;
    send(32'h100, 32'h0010_0093, 1'b1);
    send(32'h104, 32'h4585, 1'b0);
    chk("bp_full_ready", {31'b0, fd_ready}, 32'd0);
    fork
      send(32'h106, 32'h0020_0113, 1'b0);
      begin
        repeat (3) step();
        chk("bp_held_ready", {31'b0, fd_ready}, 32'd0);
        chk("bp_head_pc", id_pc, 32'h100);
        id_ready = 1'b1;
      end
    join
    drain();
    chk("bp_pops", pop_count - pops0, 32'd3);

    // Flush with a packet offered in the same cycle.
    id_ready = 1'b0;
    send(32'h200, 32'h0000_0013, 1'b1);
    send(32'h204, 32'h0000_0013, 1'b0);
    fd_pc = 32'h8b0; fd_istr = 32'h0000_0013; fd_jump = 1'b0; fd_valid = 1'b1;
    flush_en = 1'b1;
    step();
    flush_en = 1'b0; fd_valid = 1'b0;
    #1;
    chk("flush_id_valid", {31'b0, id_valid}, 32'd0);
    chk("flush_fd_ready", {31'b0, fd_ready}, 32'd1);
    id_ready = 1'b1;
    pops0 = pop_count;
    send(32'h8b0, 32'h0000_0013, 1'b0);
    drain();
    chk("flush_pops", pop_count - pops0, 32'd1);
    chk("flush_seq_err", {31'b0, seq_err}, 32'd0);

    // Discontinuity without jump: sticky error.
    send(32'h40, 32'h0000_0013, 1'b1);
    send(32'h948, 32'h0000_0013, 1'b0);
    chk("disc_seq_err", {31'b0, seq_err}, 32'd1);
    send(32'h94c, 32'h0000_0013, 1'b0);
    repeat (3) step();
    chk("disc_sticky", {31'b0, seq_err}, 32'd1);

    // Reset mid-stream with an entry buffered.
    id_ready = 1'b0;
    send(32'h950, 32'h0000_0013, 1'b0);
    rest = 1'b1;
    step(); step();
    check_reset_state("rst2");
    rest = 1'b0;
    #1;
    chk("rst2_ready", {31'b0, fd_ready}, 32'd1);

    // Same discontinuity flagged as a jump: no error.
    id_ready = 1'b1;
    send(32'h40, 32'h0000_0013, 1'b0);
    send(32'h948, 32'h0000_0013, 1'b1);
    drain();
    chk("jump_seq_err", {31'b0, seq_err}, 32'd0);

    // ctr_stop holds the head and suppresses id_valid.
    ctr_stop = 1'b1;
    send(32'h94c, 32'h00A0_0093, 1'b0);
    repeat (2) step();
    chk("stop_id_valid", {31'b0, id_valid}, 32'd0);
    chk("stop_id_pc", id_pc, 32'h94c);
    chk("stop_id_istr", id_istr, 32'h00A0_0093);
    ctr_stop = 1'b0;
    #1;
    chk("release_id_valid", {31'b0, id_valid}, 32'd1);
    chk("release_id_pc", id_pc, 32'h94c);
    drain();

    // PC wrap at the top of the address space.
    ctr_stop = 1'b1;
    send(32'hFFFF_FFFE, 32'h0000_4501, 1'b1);
    step();
    chk("wrap_pc_next", id_pc_next, 32'h0);
    chk("wrap_is_c", {31'b0, id_is_c}, 32'd1);
    ctr_stop = 1'b0;
    send(32'h0, 32'h0000_0013, 1'b0);
    drain();
    chk("wrap_seq_err", {31'b0, seq_err}, 32'd0);

    repeat (2) step();
    chk("sb_final_empty", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
